// File: rtl/ssd_capture.sv
// ssd_capture: snoops the multiplexed 4-digit seven-segment bus and
// publishes confirmed hex digits. Optional dp capture: SSD_CAPTURE_DP_EN.
module ssd_capture #(
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] ssd,
  input  logic [3:0] ssd_sel,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dp,
  output logic       valid,
  output logic       err,
  output logic       stale
);

  localparam int SW = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] TO = SW'(TIMEOUT);
  localparam logic [3:0] CONF = 4'(CONFIRM);

  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_COL = 2'd1;
  localparam logic [1:0] S_CHK = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [15:0]   slots;
  logic [3:0]    slot_dp;
  logic [3:0]    seen, seen_nxt;
  logic [3:0]    cnt;
  logic [15:0]   prev_d;
  logic [3:0]    prev_dp;
  logic [15:0]   dq;
  logic [3:0]    dpq;
  logic [SW-1:0] scnt;

  logic       sel_ok, sel_blank;
  logic [1:0] sel_idx;
  logic       seg_hit;
  logic [3:0] seg_val;
  logic       lit;
  logic       bad, wr;

  logic       same, load;
  logic [3:0] cnt_inc, cnt_new;
  logic [3:0] seen_base;
  logic [SW-1:0] scnt_inc;

  // Decode the digit select and the segment pattern of this sample.
  always_comb begin
    sel_ok    = 1'b0;
    sel_idx   = 2'd0;
    sel_blank = (ssd_sel == 4'b1111);
    case (ssd_sel)
      4'b1110: begin sel_ok = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_ok = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_ok = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_ok = 1'b1; sel_idx = 2'd3; end
      default: begin sel_ok = 1'b0; sel_idx = 2'd0; end
    endcase
    seg_hit = 1'b1;
    seg_val = 4'h0;
    case ({ssd[7:1], 1'b1})
      8'h03: seg_val = 4'h0;
      8'h9F: seg_val = 4'h1;
      8'h25: seg_val = 4'h2;
      8'h0D: seg_val = 4'h3;
      8'h99: seg_val = 4'h4;
      8'h49: seg_val = 4'h5;
      8'h41: seg_val = 4'h6;
      8'h1F: seg_val = 4'h7;
      8'h01: seg_val = 4'h8;
      8'h09: seg_val = 4'h9;
      8'h11: seg_val = 4'hA;
      8'hC1: seg_val = 4'hB;
      8'h63: seg_val = 4'hC;
      8'h85: seg_val = 4'hD;
      8'h61: seg_val = 4'hE;
      8'h71: seg_val = 4'hF;
      default: seg_hit = 1'b0;
    endcase
`ifdef SSD_CAPTURE_DP_EN
    lit = ~ssd[0];
`else
    lit = 1'b0;
`endif
    bad = en && !sel_blank && !(sel_ok && seg_hit);
    wr  = en && sel_ok && seg_hit;
  end

  // Frame bookkeeping: seen mask, next state, confirmation arithmetic.
  always_comb begin
    seen_base = (state == S_CHK) ? 4'b0000 : seen;
    if (!en || bad)
      seen_nxt = 4'b0000;
    else if (wr)
      seen_nxt = seen_base | (4'b0001 << sel_idx);
    else
      seen_nxt = seen_base;

    state_nxt = S_COL;
    if (!en)
      state_nxt = S_DIS;
    else if (state == S_COL || state == S_DIS)
      state_nxt = (seen_nxt == 4'b1111) ? S_CHK : S_COL;
    else
      state_nxt = S_COL;

    same    = ({slots, slot_dp} == {prev_d, prev_dp});
    cnt_inc = (cnt == 4'd15) ? cnt : cnt + 4'd1;
    cnt_new = same ? cnt_inc : 4'd1;
    load    = (cnt_new >= CONF) && ({slots, slot_dp} != {dq, dpq});

    scnt_inc = (scnt == {SW{1'b1}}) ? scnt : scnt + SW'(1);
  end

  // Control state and the partial-frame capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_COL;
      seen    <= 4'b0000;
      slots   <= 16'h0000;
      slot_dp <= 4'b0000;
    end else begin
      state <= state_nxt;
      seen  <= seen_nxt;
      if (bad) begin
        slots   <= 16'h0000;
        slot_dp <= 4'b0000;
      end else if (wr) begin
        slots[sel_idx*4 +: 4] <= seg_val;
        slot_dp[sel_idx]      <= lit;
      end
    end
  end

  // Confirmation counter, previous frame and published outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      prev_d  <= 16'h0000;
      prev_dp <= 4'b0000;
      dq      <= 16'h0000;
      dpq     <= 4'b0000;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= bad;
      if (!en) begin
        cnt <= 4'd0;
      end else if (state == S_CHK) begin
        cnt     <= cnt_new;
        prev_d  <= slots;
        prev_dp <= slot_dp;
        if (load) begin
          dq    <= slots;
          dpq   <= slot_dp;
          valid <= 1'b1;
        end
      end
    end
  end

  // Staleness timer: restarts on every completed frame, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt  <= '0;
      stale <= 1'b0;
    end else if (!en || state == S_CHK) begin
      scnt  <= '0;
      stale <= 1'b0;
    end else begin
      scnt  <= scnt_inc;
      stale <= (scnt_inc >= TO);
    end
  end

  assign d0 = dq[3:0];
  assign d1 = dq[7:4];
  assign d2 = dq[11:8];
  assign d3 = dq[15:12];

`ifdef SSD_CAPTURE_DP_EN
  assign dp = dpq;
`else
  logic unused_dp;
  assign unused_dp = ^{ssd[0], dpq};
  assign dp = 4'b0000;
`endif

endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture: directed scoreboard bench for ssd_capture.
// Expected frames are queued ahead and matched on every valid pulse.
module tb_ssd_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ssd;
  logic [3:0] ssd_sel;
  logic [3:0] d0, d1, d2, d3, dp;
  logic       valid, err, stale;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nerr   = 0;
  int n0, nv;
  logic [19:0] sbq[$];

  always #5 clk = ~clk;

  ssd_capture #(.CONFIRM(2), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .en(en),
    .ssd(ssd), .ssd_sel(ssd_sel),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp(dp),
    .valid(valid), .err(err), .stale(stale)
  );

  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 8'h03;  4'h1: return 8'h9F;
      4'h2: return 8'h25;  4'h3: return 8'h0D;
      4'h4: return 8'h99;  4'h5: return 8'h49;
      4'h6: return 8'h41;  4'h7: return 8'h1F;
      4'h8: return 8'h01;  4'h9: return 8'h09;
      4'hA: return 8'h11;  4'hB: return 8'hC1;
      4'hC: return 8'h63;  4'hD: return 8'h85;
      4'hE: return 8'h61;  default: return 8'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] sel, input logic [7:0] s);
    @(negedge clk);
    ssd_sel = sel;
    ssd     = s;
  endtask

  task automatic frame_raw(input logic [7:0] s0, s1, s2, s3);
    step(4'b1110, s0);
    step(4'b1101, s1);
    step(4'b1011, s2);
    step(4'b0111, s3);
  endtask

  task automatic frame(input logic [3:0] a, b, c, e);
    frame_raw(seg(a), seg(b), seg(c), seg(e));
  endtask

  task automatic flush();
    repeat (3) step(4'b1111, 8'hFF);
  endtask

  // Output monitor: every valid must match the head of the scoreboard.
  always @(posedge clk) begin
    logic [19:0] e;
    #1;
    if (err) nerr++;
    if (valid) begin
      nvalid++;
      chk("valid_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("valid_data", {12'h0, d3, d2, d1, d0, dp}, {12'h0, e});
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; ssd = 8'hFF; ssd_sel = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_digits", {d3, d2, d1, d0}, 16'h0);
    chk("rst_dp", dp, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_stale", stale, 0);
    rst = 1'b0; en = 1'b1;

    // Lock onto a steady 1,2,3,4 rotation.
    sbq.push_back({16'h4321, 4'h0});
    frame(1, 2, 3, 4);
    frame(1, 2, 3, 4);
    step(4'b1110, seg(1));
    chk("lat_check_cycle", valid, 0);
    step(4'b1101, seg(2));
    chk("lat_valid", valid, 1);
    chk("lock_digits", {d3, d2, d1, d0}, 16'h4321);
    step(4'b1011, seg(3));
    chk("valid_oneshot", valid, 0);
    step(4'b0111, seg(4));
    frame(1, 2, 3, 4);
    frame(1, 2, 3, 4);
    flush();
    chk("repeat_no_valid", nvalid, 1);

    // Single-frame glitch must not publish; two frames must.
    frame(1, 2, 6, 4);
    frame(1, 2, 3, 4);
    frame(1, 2, 3, 4);
    flush();
    chk("glitch_no_valid", nvalid, 1);
    sbq.push_back({16'h4621, 4'h0});
    frame(1, 2, 6, 4);
    frame(1, 2, 6, 4);
    flush();
    chk("hold_valid", nvalid, 2);
    chk("hold_digits", {d3, d2, d1, d0}, 16'h4621);

    // Illegal select and undecodable pattern.
    n0 = nerr;
    step(4'b1110, seg(1));
    step(4'b1101, seg(2));
    step(4'b1100, seg(3));
    step(4'b1111, 8'hFF);
    chk("err_sel", err, 1);
    step(4'b1111, 8'hFF);
    chk("err_oneshot", err, 0);
    step(4'b1110, seg(1));
    step(4'b1101, seg(2));
    step(4'b1110, 8'hFF);
    step(4'b1111, 8'hFF);
    chk("err_pattern", err, 1);
    step(4'b1111, 8'hFF);
    chk("err_count", nerr, n0 + 2);
    sbq.push_back({16'h4321, 4'h0});
    frame(1, 2, 3, 4);
    frame(1, 2, 3, 4);
    chk("err_no_early", nvalid, 2);
    flush();
    chk("err_restart_valid", nvalid, 3);
    chk("err_restart_digits", {d3, d2, d1, d0}, 16'h4321);

    // Blank bus long enough to go stale.
    n0 = nerr;
    repeat (1000) step(4'b1111, 8'hFF);
    chk("stale_early", stale, 0);
    repeat (100) step(4'b1111, 8'hFF);
    chk("stale_set", stale, 1);
    repeat (900) step(4'b1111, 8'hFF);
    chk("stale_level", stale, 1);
    chk("blank_no_err", nerr, n0);
    frame(1, 2, 3, 4);
    chk("stale_pre_check", stale, 1);
    step(4'b1111, 8'hFF);
    chk("stale_in_check", stale, 1);
    step(4'b1111, 8'hFF);
    chk("stale_cleared", stale, 0);

    // Digit 1 with its decimal point lit.
`ifdef SSD_CAPTURE_DP_EN
    sbq.push_back({16'h4321, 4'b0010});
`endif
    frame_raw(seg(1), 8'h24, seg(3), seg(4));
    frame_raw(seg(1), 8'h24, seg(3), seg(4));
    flush();
`ifdef SSD_CAPTURE_DP_EN
    chk("dp_valid", nvalid, 4);
    chk("dp_value", dp, 4'b0010);
`else
    chk("dp_ignored", nvalid, 3);
    chk("dp_tied", dp, 0);
`endif

    // Disable for 10 cycles: outputs held, nothing reported.
    n0 = nerr; nv = nvalid;
    en = 1'b0;
    step(4'b1100, seg(5));
    frame(5, 6, 7, 8);
    frame(5, 6, 7, 8);
    step(4'b1111, 8'hFF);
    chk("dis_digits", {d3, d2, d1, d0}, 16'h4321);
`ifdef SSD_CAPTURE_DP_EN
    chk("dis_dp", dp, 4'b0010);
`else
    chk("dis_dp", dp, 0);
`endif
    chk("dis_no_valid", nvalid, nv);
    chk("dis_no_err", nerr, n0);
    chk("dis_stale", stale, 0);
    en = 1'b1;

    // Reset mid-frame drops the partial frame.
    step(4'b1110, seg(5));
    step(4'b1101, seg(6));
    rst = 1'b1;
    #1;
    chk("rst_async_digits", {d3, d2, d1, d0}, 16'h0);
    chk("rst_async_dp", dp, 0);
    @(negedge clk);
    rst = 1'b0;
    sbq.push_back({16'h8765, 4'h0});
    frame(5, 6, 7, 8);
    frame(5, 6, 7, 8);
    chk("post_rst_no_early", nvalid, nv);
    flush();
    chk("post_rst_valid", nvalid, nv + 1);
    chk("post_rst_digits", {d3, d2, d1, d0}, 16'h8765);

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_capture.md
# ssd_capture

Snooping decoder for the time-multiplexed four-digit seven-segment bus (8-bit segment lines plus 4-bit active-low digit select) produced by the display driver. It rebuilds the four hex digit values from the multiplexed stream, qualifies them over consecutive identical frames, and publishes them with a one-cycle valid strobe. It is used for on-chip loopback self-check of score/status display paths and as a bus monitor in system benches. It runs on the same clock as the display driver.

## Interface
- CONFIRM, 2: identical complete frames required before outputs update (1..15).
- TIMEOUT, 1024: cycles without a completed frame before stale asserts (≥8; counter width = clog2(TIMEOUT)+1).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  capture enable.
- ssd  in  8  segment lines {a,b,c,d,e,f,g,dp}, bit7=a, active-low.
- ssd_sel  in  4  digit select, active-low; 1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3.
- d0, d1, d2, d3  out  4 each  confirmed digit values.
- dp  out  4  confirmed decimal points (bit i = digit i, 1 = lit).
- valid  out  1  one-cycle pulse when d0..d3/dp change.
- err  out  1  one-cycle pulse on illegal select or undecodable pattern.
- stale  out  1  level; no complete frame for TIMEOUT cycles.

## Operation
- Decode table, ssd[7:1] vs code>>1 (dp masked): 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 A=11 b=C1 C=63 d=85 E=61 F=71 (hex, dp bit 1 = off).
- Sampling every cycle while en=1:
  - ssd_sel=1111: blank, ignored, no error.
  - One-hot-low ssd_sel with decodable pattern: value to slot[idx], seen[idx]=1; re-selecting an already-seen slot overwrites it (latest wins).
  - Any other ssd_sel (two or more zeros), or no table match: err pulse, seen cleared, slots discarded, cnt unchanged.
- States: DISABLED, COLLECT, CHECK.
  - DISABLED (en=0): seen, cnt, stale counter and stale cleared; d*/dp held; no valid/err.
  - en rising: COLLECT.
  - COLLECT to CHECK when seen==1111.
  - CHECK lasts 1 cycle:
    - frame=={prev}: cnt=min(cnt+1,15); otherwise cnt=1.
    - prev=frame; seen cleared.
    - If cnt (new value) ≥CONFIRM and frame differs from d*/dp: outputs load, valid pulses.
    - Returns to COLLECT.
    - The bus sample taken in the CHECK cycle is processed normally and counts toward the next frame.
- Identical confirmed frames repeating: no further valid.
- stale: counter increments each cycle in COLLECT/CHECK, resets on every CHECK, saturates; stale=1 when counter ≥TIMEOUT, clears on the next CHECK.
- rst mid-frame: everything to reset values immediately; partial frame lost.

## Timing
- Reset values: d0..d3=0, dp=0, valid=0, err=0, stale=0, state COLLECT, seen=0, cnt=0, prev=0.
- Last digit of a frame sampled in cycle N; CHECK in N+1; d*/dp/valid registered visible in N+2.
- err is registered; visible the cycle after the offending sample.
- valid and err may both assert in the same cycle.
- With a 4-cycle driver rotation and CONFIRM=2, the first valid arrives 2 cycles after the last digit of the 2nd identical frame.

## Configuration
- SSD_CAPTURE_DP_EN defined:
  - dp bit captured per slot, participates in frame comparison and change detection.
  - dp output driven.
- Undefined:
  - dp bit ignored entirely.
  - dp output tied 0.
  - Frames differing only in dp count as identical.

## Test plan
- Reset then rotation 1110/9F, 1101/25, 1011/0D, 0111/99 repeating, CONFIRM=2 -> single valid with d0=1,d1=2,d2=3,d3=4; no further valid while pattern repeats.
- After lock, change digit2 to 0x41 for one frame, then revert -> no valid; hold 0x41 two frames -> valid, d2=6.
- Inject ssd_sel=1100 mid-frame, then ssd=0xFF with sel=1110 -> err pulse each time, seen cleared, confirmation restarts with cnt=1 on the next full frame.
- ssd_sel=1111 for 2000 cycles, TIMEOUT=1024 -> stale=1 from cycle 1024, no err; a following complete frame clears stale the cycle after CHECK.
- With SSD_CAPTURE_DP_EN, digit1 code 0x24 (2 with dp lit) for two frames -> valid, d1=2, dp=0010; without the macro -> no valid if d1 already 2.
- Assert rst mid-frame and toggle en=0 for 10 cycles -> outputs 0 after rst, held during en=0, no valid until two fresh frames.
